// File: rtl/a09_pkg.sv
// rtl/a09_pkg.sv - shared A09 types and constants for the output-port UART
package a09_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        S_Idle,
        S_Start,
        S_Data,
        S_Stop
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO buffering CPU output words
//
// Ports:
//   Clk, Reset   rising-edge clock, synchronous active-high reset
//   Push, DIn    write request and word; ignored when full unless a pop coincides
//   Pop          read request; ignored when empty
//   DOut         head word (combinational read of the head entry)
//   Empty, Full  occupancy flags derived from the registered count
module sync_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Push,
    input  logic             Pop,
    input  logic [Width-1:0] DIn,
    output logic [Width-1:0] DOut,
    output logic             Empty,
    output logic             Full
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign Empty   = (count == '0);
    assign Full    = (count == CNT_DEPTH);
    assign DOut    = mem[rd_ptr];
    assign do_pop  = Pop && !Empty;
    // A push into a full FIFO is allowed only when the head leaves this same cycle
    assign do_push = Push && (!Full || do_pop);

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= DIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - A09 output-port word buffer and 8N1 UART transmitter
//
// Ports:
//   Clk, Reset  rising-edge clock, synchronous active-high reset
//   Wr, Data    one-cycle CPU write strobe and the word written
//   Tx          UART line, idle high, registered
//   Busy        a frame is on the line or words are waiting
//   Full        FIFO holds FifoDepth words
//   Overflow    sticky flag: a write was dropped because the FIFO was full
// Words go out most-significant byte first; each byte is start, 8 data bits
// LSB first, stop, every bit held ClksPerBit clocks.
module out_port_uart_tx
    import a09_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int ClksPerBit = 16,
    parameter int FifoDepth  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Wr,
    input  logic [DataWidth-1:0] Data,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Full,
    output logic                 Overflow
);

    localparam int BYTES = DataWidth / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = $clog2(ClksPerBit);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(ClksPerBit - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    tx_state_t            state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [IDX_W-1:0]     byte_idx, idx_n;
    logic [DataWidth-1:0] word_reg, word_n;
    logic [7:0]           shift_reg, shift_n;
    logic                 tx_n;
    logic                 line_active;
    logic                 pop;
    logic [DataWidth-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 baud_last;

    function automatic logic [7:0] byte_of(input logic [DataWidth-1:0] w,
                                           input logic [IDX_W-1:0]     k);
        logic [DataWidth-1:0] s;
        s = w >> {k, 3'b000};
        return s[7:0];
    endfunction

    sync_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .Push  (Wr),
        .Pop   (pop),
        .DIn   (Data),
        .DOut  (fifo_dout),
        .Empty (fifo_empty),
        .Full  (fifo_full)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign Full      = fifo_full;
    // Tx lags the state by one register stage, so line_active keeps Busy high
    // until the final stop bit has actually finished on the pin.
    assign Busy      = (state != S_Idle) || !fifo_empty || line_active;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        idx_n   = byte_idx;
        word_n  = word_reg;
        shift_n = shift_reg;
        pop     = 1'b0;
        tx_n    = UART_IDLE;
        case (state)
            S_Idle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_n  = fifo_dout;
                    idx_n   = '0;
                    shift_n = byte_of(fifo_dout, IDX_LAST);
                    baud_n  = '0;
                    state_n = S_Start;
                end
            end
            S_Start: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_Data;
                end else begin
                    baud_n = baud_cnt + CNT_ONE;
                end
            end
            S_Data: begin
                tx_n = shift_reg[0];
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_n = S_Stop;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + CNT_ONE;
                end
            end
            S_Stop: begin
                tx_n = UART_IDLE;
                if (baud_last) begin
                    baud_n = '0;
                    if (byte_idx != IDX_LAST) begin
                        idx_n   = byte_idx + IDX_ONE;
                        shift_n = byte_of(word_reg, IDX_LAST - idx_n);
                        state_n = S_Start;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word: no idle bit between frames
                        pop     = 1'b1;
                        word_n  = fifo_dout;
                        idx_n   = '0;
                        shift_n = byte_of(fifo_dout, IDX_LAST);
                        state_n = S_Start;
                    end else begin
                        state_n = S_Idle;
                    end
                end else begin
                    baud_n = baud_cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = S_Idle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_Idle;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            word_reg    <= '0;
            shift_reg   <= '0;
            Tx          <= UART_IDLE;
            line_active <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_cnt     <= bit_n;
            byte_idx    <= idx_n;
            word_reg    <= word_n;
            shift_reg   <= shift_n;
            Tx          <= tx_n;
            line_active <= (state != S_Idle);
            if (Wr && fifo_full && !pop) begin
                Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb/tb_out_port_uart_tx.sv - self-checking bench for out_port_uart_tx
`timescale 1ns/1ps
module tb_out_port_uart_tx;

    localparam int DEPTH = 4;
    localparam int BYTES = 2;
    localparam int CPB_M = 16;
    localparam int CPB_F = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] data = '0;
    logic        tx_m, busy_m, full_m, ovf_m;
    logic        tx_f, busy_f, full_f, ovf_f;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    out_port_uart_tx #(.DataWidth(16), .ClksPerBit(CPB_M), .FifoDepth(DEPTH)) dut_main (
        .Clk(clk), .Reset(reset), .Wr(wr), .Data(data),
        .Tx(tx_m), .Busy(busy_m), .Full(full_m), .Overflow(ovf_m)
    );

    out_port_uart_tx #(.DataWidth(16), .ClksPerBit(CPB_F), .FifoDepth(DEPTH)) dut_fast (
        .Clk(clk), .Reset(reset), .Wr(wr), .Data(data),
        .Tx(tx_f), .Busy(busy_f), .Full(full_f), .Overflow(ovf_f)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO as a word queue, line as a queue of scheduled levels.
    typedef logic [15:0] word_q_t[$];
    typedef bit          bit_q_t[$];
    typedef struct {
        int free_edge;
        bit ovf;
        bit showing;
        bit tx;
        bit busy;
        bit full;
    } model_t;

    model_t  m_main, m_fast;
    word_q_t fq_m, fq_f;
    bit_q_t  lq_m, lq_f;
    bit      model_on = 1'b0;

    task automatic model_step(input int cpb, input bit rst, input bit w_en, input logic [15:0] d,
                              input int t, ref model_t m, ref word_q_t fq, ref bit_q_t lq);
        bit          do_pop;
        bit          was_full;
        logic [15:0] w;
        if (rst) begin
            fq.delete();
            lq.delete();
            m.free_edge = t;
            m.ovf       = 1'b0;
            m.showing   = 1'b0;
            m.tx        = 1'b1;
        end else begin
            if (lq.size() > 0) begin
                m.tx      = lq.pop_front();
                m.showing = 1'b1;
            end else begin
                m.tx      = 1'b1;
                m.showing = 1'b0;
            end
            do_pop   = (fq.size() > 0) && (t >= m.free_edge);
            was_full = (fq.size() == DEPTH);
            if (do_pop) begin
                w = fq.pop_front();
                for (int b = BYTES - 1; b >= 0; b--) begin
                    logic [7:0] by;
                    by = 8'(w >> (8 * b));
                    repeat (cpb) lq.push_back(1'b0);
                    for (int i = 0; i < 8; i++) repeat (cpb) lq.push_back(by[i]);
                    repeat (cpb) lq.push_back(1'b1);
                end
                m.free_edge = t + BYTES * 10 * cpb;
            end
            if (w_en) begin
                if (!was_full || do_pop) fq.push_back(d);
                else m.ovf = 1'b1;
            end
        end
        m.busy = (fq.size() > 0) || (lq.size() > 0) || m.showing;
        m.full = (fq.size() == DEPTH);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(CPB_M, reset, wr, data, cyc, m_main, fq_m, lq_m);
            model_step(CPB_F, reset, wr, data, cyc, m_fast, fq_f, lq_f);
            if (reset) model_on = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("tx_main",   tx_m,   m_main.tx);
                check("busy_main", busy_m, m_main.busy);
                check("full_main", full_m, m_main.full);
                check("ovf_main",  ovf_m,  m_main.ovf);
                check("tx_fast",   tx_f,   m_fast.tx);
                check("busy_fast", busy_f, m_fast.busy);
                check("full_fast", full_f, m_fast.full);
                check("ovf_fast",  ovf_f,  m_fast.ovf);
            end
        end
    end

    // Independent UART receiver on the main line, sampling mid-bit
    logic [7:0] rxq[$];
    logic [7:0] exp_rx[$];
    bit         dactive = 1'b0;
    int         dcnt = 0;
    logic [7:0] dbyte = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                dactive = 1'b0;
            end else if (!dactive) begin
                if (tx_m == 1'b0) begin
                    dactive = 1'b1;
                    dcnt    = 0;
                end
            end else begin
                dcnt++;
                if (dcnt >= CPB_M && dcnt < 9 * CPB_M && (dcnt % CPB_M) == CPB_M / 2)
                    dbyte[(dcnt / CPB_M) - 1] = tx_m;
                if (dcnt == 9 * CPB_M + CPB_M / 2) begin
                    check("rx_stop_bit", tx_m, 1);
                    rxq.push_back(dbyte);
                    dactive = 1'b0;
                end
            end
        end
    end

    task automatic check_rx();
        check("rx_count", rxq.size(), exp_rx.size());
        for (int i = 0; i < rxq.size() && i < exp_rx.size(); i++)
            check("rx_byte", rxq[i], exp_rx[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] d);
        wr   = 1'b1;
        data = d;
        @(negedge clk);
        wr   = 1'b0;
        data = 16'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy_m || busy_f) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_bound", busy_m | busy_f, 0);
    endtask

    initial begin
        int   w;
        int   fall;
        int   bf;
        int   t0;
        logic [39:0] v;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_tx", tx_m, 1);
        check("reset_busy", busy_m, 0);
        check("reset_full", full_m, 0);
        check("reset_ovf", ovf_m, 0);

        // Single word: latency, byte order, busy span
        rxq.delete();
        write_word(16'hA5C3);
        w = cyc;
        fall = -1;
        for (int i = 0; i < 10 && fall < 0; i++) begin
            if (tx_m == 1'b0) fall = cyc;
            else @(negedge clk);
        end
        check("start_latency", fall - w, 2);
        bf = -1;
        for (int i = 0; i < 400 && bf < 0; i++) begin
            @(negedge clk);
            if (!busy_m) bf = cyc;
        end
        check("busy_span", bf - fall, 320);
        wait_idle(200);
        exp_rx = '{8'hA5, 8'hC3};
        check_rx();

        // Six back-to-back writes: fifth fills the FIFO, sixth overflows
        do_reset();
        rxq.delete();
        for (int i = 1; i <= 6; i++) begin
            write_word(16'(i));
            if (i == 5) check("full_after_fill", full_m, 1);
        end
        check("overflow_set", ovf_m, 1);
        wait_idle(2500);
        exp_rx = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
        check_rx();

        // Write on the exact pop cycle while full is accepted
        do_reset();
        rxq.delete();
        w = 0;
        for (int i = 0; i < 5; i++) begin
            write_word(16'h0011 + 16'(i));
            if (i == 0) w = cyc;
        end
        check("full_before_pop", full_m, 1);
        while (cyc < w + 320) @(negedge clk);
        write_word(16'h99AA);
        check("ovf_on_pop_write", ovf_m, 0);
        check("full_kept", full_m, 1);
        wait_idle(3000);
        exp_rx = '{8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00, 8'h14,
                   8'h00, 8'h15, 8'h99, 8'hAA};
        check_rx();

        // Reset in the middle of a data bit
        do_reset();
        rxq.delete();
        write_word(16'hBEEF);
        w = cyc;
        while (cyc < w + 29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_tx", tx_m, 1);
        check("midreset_busy", busy_m, 0);
        check("midreset_full", full_m, 0);
        check("midreset_ovf", ovf_m, 0);
        rxq.delete();
        write_word(16'h1234);
        wait_idle(500);
        exp_rx = '{8'h12, 8'h34};
        check_rx();

        // Two clocks per bit: literal line waveform for 0xFF00
        do_reset();
        write_word(16'hFF00);
        w = cyc;
        while (cyc < w + 2) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            v[i] = tx_f;
            @(negedge clk);
        end
        check("fast_waveform", v, 40'b11_0000000000000000_00_11_1111111111111111_00);
        wait_idle(500);

        // Program-style run: three output writes, then quiet until 15 us
        do_reset();
        rxq.delete();
        t0 = cyc;
        write_word(16'h0102);
        repeat (2) @(negedge clk);
        write_word(16'hABCD);
        repeat (5) @(negedge clk);
        write_word(16'h7E81);
        while (cyc < t0 + 1500) @(negedge clk);
        check("program_busy_main", busy_m, 0);
        check("program_busy_fast", busy_f, 0);
        exp_rx = '{8'h01, 8'h02, 8'hAB, 8'hCD, 8'h7E, 8'h81};
        check_rx();

        // Random writes; model checks every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                wr   = 1'b1;
                data = 16'($urandom);
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
        end
        wr = 1'b0;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
